elevator_call_dispatcher: RTL and testbench

Services the latched floor-call bits held in the elevator's JK flip-flop request bank. It picks the next floor with a collective (SCAN) policy, drives the car motor one floor at a time, and opens the door at the served floor. It returns a one-cycle clear pulse to that floor's flip-flop `k` input, so it is the consuming end of the request register: the buttons set the bits and this block clears them. It sits between the request bank and the motor/door drivers.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/call_scan.sv | 46 ++++
 rtl/elevator_call_dispatcher.sv | 134 +++++++++++++
 tb/tb_elevator_call_dispatcher.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types: controller state encoding and the floor-index width helper.
// No logic; used by the dispatcher, request bank and display.
// No flow control.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        SERVE = 2'd2,
        DOOR  = 2'd3
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int floor_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/call_scan.sv
// Combinational scan of the latched calls relative to the car position and sweep direction.
// Latency: zero cycles (pure combinational).
// Backpressure: none; it only observes the request bank.
module call_scan
    import elevator_pkg::*;
#(
    parameter  int FLOORS = 4,
    localparam int FW     = floor_width(FLOORS)
) (
    input  logic [FLOORS-1:0] call_pending,
    input  logic [FW-1:0]     floor_now,
    input  logic              dir_up,
    output logic              above,
    output logic              below,
    output logic              here,
    output logic              next_here,
    output logic              next_beyond,
    output logic              at_end
);

    int cur;

    always_comb begin
        cur         = int'(floor_now);
        above       = 1'b0;
        below       = 1'b0;
        here        = 1'b0;
        next_here   = 1'b0;
        next_beyond = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > cur) above |= call_pending[i];
            if (i < cur) below |= call_pending[i];
            if (i == cur) here |= call_pending[i];
            // "next" is the floor the car reaches when the current move completes
            if (dir_up) begin
                if (i == cur + 1) next_here   |= call_pending[i];
                if (i > cur + 1)  next_beyond |= call_pending[i];
            end else begin
                if (i + 1 == cur) next_here   |= call_pending[i];
                if (i + 1 < cur)  next_beyond |= call_pending[i];
            end
        end
        at_end = dir_up ? (cur == FLOORS - 1) : (cur == 0);
    end

endmodule

// File: rtl/elevator_call_dispatcher.sv
// Collective (SCAN) call dispatcher: moves the car floor by floor, opens the door, clears served calls.
// Latency: clear pulse one cycle after a call is seen at the car's floor; TRAVEL_CYCLES per floor moved.
// Backpressure: none; calls stay latched in the request bank until the one-hot clear pulse consumes them.
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter  int FLOORS        = 4,
    parameter  int TRAVEL_CYCLES = 8,
    parameter  int DOOR_CYCLES   = 16,
    localparam int FW            = floor_width(FLOORS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FLOORS-1:0] call_pending,
    output logic [FLOORS-1:0] call_clear,
    output logic [FW-1:0]     floor_now,
    output logic              motor_up,
    output logic              motor_down,
    output logic              door_open,
    output logic              dir_up,
    output logic              busy
);

    localparam int TW = floor_width(TRAVEL_CYCLES);
    localparam int DW = floor_width(DOOR_CYCLES);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

    state_t            state, state_nxt;
    logic [FW-1:0]     floor_nxt;
    logic              dir_nxt;
    logic [TW-1:0]     travel_cnt, travel_nxt;
    logic [DW-1:0]     door_cnt, door_nxt;
    logic [FLOORS-1:0] floor_hot;

    logic above, below, here, next_here, next_beyond, at_end;

    call_scan #(
        .FLOORS (FLOORS)
    ) u_scan (
        .call_pending (call_pending),
        .floor_now    (floor_now),
        .dir_up       (dir_up),
        .above        (above),
        .below        (below),
        .here         (here),
        .next_here    (next_here),
        .next_beyond  (next_beyond),
        .at_end       (at_end)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            floor_now  <= '0;
            dir_up     <= 1'b1;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            floor_now  <= floor_nxt;
            dir_up     <= dir_nxt;
            travel_cnt <= travel_nxt;
            door_cnt   <= door_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        floor_nxt  = floor_now;
        dir_nxt    = dir_up;
        travel_nxt = travel_cnt;
        door_nxt   = door_cnt;
        unique case (state)
            IDLE: begin
                if (here) begin
                    state_nxt = SERVE;
                end else if (above && (dir_up || !below)) begin
                    state_nxt  = MOVE;
                    dir_nxt    = 1'b1;
                    travel_nxt = TRAVEL_LOAD;
                end else if (below) begin
                    state_nxt  = MOVE;
                    dir_nxt    = 1'b0;
                    travel_nxt = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (travel_cnt != '0) begin
                    travel_nxt = travel_cnt - TW'(1);
                end else if (at_end) begin
                    // calls withdrawn under us; never step past the shaft ends
                    state_nxt = IDLE;
                end else begin
                    floor_nxt = dir_up ? floor_now + FW'(1) : floor_now - FW'(1);
                    if (next_here) begin
                        state_nxt = SERVE;
                    end else if (next_beyond) begin
                        travel_nxt = TRAVEL_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SERVE: begin
                state_nxt = DOOR;
                door_nxt  = DOOR_LOAD;
            end
            DOOR: begin
                if (here) begin
                    door_nxt = DOOR_LOAD;
                end else if (door_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    door_nxt = door_cnt - DW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        floor_hot = '0;
        for (int i = 0; i < FLOORS; i++) begin
            floor_hot[i] = (int'(floor_now) == i);
        end
        call_clear = ((state == SERVE) || (state == DOOR && here)) ? floor_hot : '0;
        motor_up   = (state == MOVE) && dir_up;
        motor_down = (state == MOVE) && !dir_up;
        door_open  = (state == DOOR);
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench: a cycle-by-cycle expectation table plus a hand-written mid-move reset sequence.
// The request bank is modelled in the bench: set bits OR in, call_clear knocks them down at the edge.
module tb_elevator_call_dispatcher;

    localparam int FLOORS = 4;
    localparam int TRAVEL = 8;
    localparam int DOORC  = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] call_pending = 4'b0000;
    logic [3:0] call_clear;
    logic [1:0] floor_now;
    logic       motor_up, motor_down, door_open, dir_up, busy;

    elevator_call_dispatcher #(
        .FLOORS        (FLOORS),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOORC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .call_pending (call_pending),
        .call_clear   (call_clear),
        .floor_now    (floor_now),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] clr;
        logic [1:0] fl;
        logic       mu;
        logic       md;
        logic       door;
        logic       dir;
        logic       busy;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [3:0] set;
        int         n;
        obs_t       exp;
    } vec_t;

    vec_t tbl[$];
    obs_t obs;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] set, input int n,
                                input logic [3:0] clr, input logic [1:0] fl, input logic mu,
                                input logic md, input logic door, input logic dir, input logic bsy);
        vec_t v;
        v.rst = rst;
        v.set = set;
        v.n   = n;
        v.exp = {clr, fl, mu, md, door, dir, bsy};
        return v;
    endfunction

    // One clock: observe mid-cycle, then let the modelled flip-flops take the clear pulse.
    task automatic tick();
        logic [3:0] clr;
        #2;
        obs = {call_clear, floor_now, motor_up, motor_down, door_open, dir_up, busy};
        clr = call_clear;
        @(posedge clock);
        #1;
        call_pending = call_pending & ~clr;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    initial begin
        int cnt;

        //        rst set     n    clr     fl mu md dr dir busy
        tbl.push_back(mk(0, 4'b0000,   3, 4'b0000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 100, 4'b0000, 0, 0, 0, 0, 1, 0));
        // call at the car's own floor
        tbl.push_back(mk(1, 4'b0001,   1, 4'b0000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0001, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   3, 4'b0000, 0, 0, 0, 0, 1, 0));
        // 0 -> 3 without stopping at 1 or 2
        tbl.push_back(mk(1, 4'b1000,   1, 4'b0000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 2, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b1000, 3, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 3, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   2, 4'b0000, 3, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0000,   2, 4'b0000, 0, 0, 0, 0, 1, 0));
        // up to 2, re-press in the fifth open cycle holds the door 5+16 cycles
        tbl.push_back(mk(1, 4'b0100,   1, 4'b0000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0100, 2, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   4, 4'b0000, 2, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0100,   1, 4'b0100, 2, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 2, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   2, 4'b0000, 2, 0, 0, 0, 1, 0));
        // at 2 sweeping up, calls 3 and 1: finish the up sweep, then reverse two floors down
        tbl.push_back(mk(1, 4'b1010,   1, 4'b0000, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 2, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b1000, 3, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 3, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0000, 3, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 3, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 2, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0010, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0000,   2, 4'b0000, 1, 0, 0, 0, 0, 0));
        // current floor wins over others; with nothing below, the down sweep turns up
        tbl.push_back(mk(1, 4'b1110,   1, 4'b0000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0010, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0100, 2, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 2, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b0000, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000,   8, 4'b0000, 2, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   1, 4'b1000, 3, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0000,  16, 4'b0000, 3, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0000,   2, 4'b0000, 3, 0, 0, 0, 1, 0));

        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (tbl[s]) begin
            reset        = tbl[s].rst;
            call_pending = call_pending | tbl[s].set;
            for (int c = 0; c < tbl[s].n; c++) begin
                tick();
                n_checks++;
                if (obs !== tbl[s].exp) begin
                    n_fail++;
                    $display("FAIL vec%0d cyc%0d: got clr=%b fl=%0d up=%b dn=%b door=%b dir=%b busy=%b, want clr=%b fl=%0d up=%b dn=%b door=%b dir=%b busy=%b",
                             s, c, obs.clr, obs.fl, obs.mu, obs.md, obs.door, obs.dir, obs.busy,
                             tbl[s].exp.clr, tbl[s].exp.fl, tbl[s].exp.mu, tbl[s].exp.md,
                             tbl[s].exp.door, tbl[s].exp.dir, tbl[s].exp.busy);
                end
            end
        end
        chk("table_pending_drained", 32'(call_pending), 32'h0);

        // reset pulled low between floors 1 and 2 must act immediately
        reset = 1'b0;
        tick();
        reset        = 1'b1;
        call_pending = 4'b0100;
        repeat (11) tick();
        chk("mid_move_floor", 32'(obs.fl), 32'd1);
        chk("mid_move_motor", 32'(obs.mu), 32'd1);
        #2;
        chk("pre_reset_motor_live", 32'(motor_up), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_motor_up",   32'(motor_up),   32'd0);
        chk("rst_motor_down", 32'(motor_down), 32'd0);
        chk("rst_floor",      32'(floor_now),  32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_door",       32'(door_open),  32'd0);
        chk("rst_dir",        32'(dir_up),     32'd1);
        chk("rst_clear",      32'(call_clear), 32'd0);
        repeat (4) begin
            @(posedge clock);
            #3;
            chk("rst_hold_clear", 32'(call_clear), 32'd0);
            chk("rst_hold_busy",  32'(busy),       32'd0);
        end
        chk("rst_call_kept", 32'(call_pending), 32'h4);

        // the uncleared call is still served after release: 1 idle + 16 move cycles, then clear
        @(posedge clock);
        #1;
        reset = 1'b1;
        cnt   = 0;
        do begin
            tick();
            cnt++;
        end while (obs.clr == 4'b0000 && cnt < 60);
        chk("restart_clear",   32'(obs.clr), 32'h4);
        chk("restart_latency", 32'(cnt),     32'd18);
        chk("restart_floor",   32'(obs.fl),  32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
